add16_pipe: RTL and testbench
=============================

// Module: add16_pipe
// PURPOSE
//  Two-stage pipelined 16-bit add/subtract unit built from 4-bit carry-lookahead groups.
//  Sits between the execute operand muxes and the ALU result mux, and drives the flag register.
//  Stage 1 adds the low byte and registers the group carry c8; stage 2 adds the high byte and
//  computes the flags. valid/ready handshake on both sides; sustains one operation per cycle.
// PARAMETERS
//  WIDTH    16  operand width; fixed at 16, checked at elaboration (must be 4*GROUPS)
//  GROUPS    4  number of 4-bit CLA groups; 2 groups per stage
// PORTS
//  clk        in   1   clock, rising edge
//  rst_n      in   1   synchronous reset, active low
//  in_valid   in   1   operands valid
//  in_ready   out  1   unit accepts operands this cycle
//  a          in   16  operand A
//  b          in   16  operand B
//  op_sub     in   1   1: A-B (B inverted, carry-in forced to 1); 0: A+B (carry-in 0)
//  out_valid  out  1   result valid
//  out_ready  in   1   consumer takes result this cycle
//  sum        out  16  result
//  cout       out  1   carry out of bit 15 (for subtract: 1 means no borrow)
//  ovfl       out  1   two's-complement signed overflow
//  zero       out  1   sum == 16'h0000 (after saturation, if compiled in)
// BEHAVIOUR
//  - Reset (rst_n=0 at a clk edge): v1, v2, out_valid = 0; sum, cout, ovfl, zero = 0; in_ready = 1 the next cycle.
//  - Transfers: input on in_valid&in_ready; output on out_valid&out_ready.
//  - Stage 2 ready: r2 = ~v2 | out_ready.
//  - Stage 1 ready: in_ready = ~v1 | r2. Combinational path from out_ready to in_ready; no bubble under full throughput.
//  - Stage 1 capture: low sum[7:0]; c8; a[15:8]; b'[15:8] (b'=b^{16{op_sub}}); op_sub. v1 <= in_valid when in_ready.
//  - Stage 2 capture when r2: high byte = a[15:8]+b'[15:8]+c8. v2 <= v1.
//  - Latency: 2 cycles from input transfer to out_valid (out_ready held 1).
//  - Stall: while out_valid & ~out_ready, sum/cout/ovfl/zero hold bit-stable.
//  - Stall: stage 1 holds when ~r2. Both stages full => in_ready=0.
//  - Same-cycle drain and fill in either stage is legal: a new item replaces the one leaving.
//  - ovfl = (a[15]==b'[15]) & (raw[15]!=a[15]).
//  - Arithmetic wraps modulo 2^16; cout is bit 16 of the full-width sum.
//  - Mid-operation reset discards in-flight items; no output transfer occurs in the reset cycle.
//  - Pipeline registers that hold data are not reset; only the valid bits and output flags are.
// CONFIGURATION
//  ADD16_PIPE_SAT_EN defined:
//   - On ovfl, sum clamps to 16'h7FFF (a[15]=0) or 16'h8000 (a[15]=1).
//   - ovfl still reports the overflow; cout is unchanged (raw carry); zero is computed on the clamped sum.
//  ADD16_PIPE_SAT_EN undefined: sum is the raw wrapped result; no clamp logic is present.
// STRUCTURE
//  - Shared package alu_pkg: WIDTH, GROUP_W=4, typedef word_t [15:0].
//  - Shared package alu_pkg: flags struct {cout, ovfl, zero}.
//  - Sub-module add8_stage: two chained cla_4 groups plus the stage valid/data register and handshake.
//    Instantiated twice; stage 2 adds the flag/saturation logic on top of it.
// TESTING
//  1 ADD, out_ready=1: a=16'h00FF, b=16'h0001, op_sub=0 -> 2 cycles later sum=16'h0100, cout=0, ovfl=0, zero=0.
//  2 SUB to zero: a=16'h1234, b=16'h1234, op_sub=1 -> sum=16'h0000, cout=1, zero=1, ovfl=0.
//  3 Signed overflow: a=16'h7FFF, b=16'h0001, op_sub=0 -> ovfl=1.
//      SAT_EN off: sum=16'h8000. SAT_EN on: sum=16'h7FFF.
//  4 Back-pressure: stream 4 ops back to back, out_ready=0 for 3 cycles.
//      -> in_ready falls after 2 accepts; outputs held stable; all 4 results appear in order, none lost or duplicated.
//  5 Full throughput: 16 random ops, in_valid=out_ready=1 throughout.
//      -> one result per cycle after 2-cycle fill; results match the reference model.
//  6 Reset mid-flight: 2 ops in flight, rst_n=0 for 1 cycle -> out_valid=0, sum=0, in_ready=1; no stale result afterwards.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU types: operand width, CLA group width and the result flag bundle.
package alu_pkg;

    localparam int unsigned WIDTH   = 16;
    localparam int unsigned GROUP_W = 4;
    localparam int unsigned GROUPS  = WIDTH / GROUP_W;

    typedef logic [WIDTH-1:0] word_t;

    typedef struct packed {
        logic cout;
        logic ovfl;
        logic zero;
    } flags_t;

    // Stage 1 -> stage 2 payload: high operand bytes, group carry and finished low byte.
    typedef struct packed {
        logic [7:0] a_hi;
        logic [7:0] b_hi;
        logic       c8;
        logic [7:0] lo;
    } s1_t;

    typedef struct packed {
        flags_t flags;
        word_t  sum;
    } res_t;

endpackage

// File: rtl/add8_stage.sv
// One pipeline stage: an 8-bit adder from two chained CLA groups, plus a
// valid/ready register slice carrying a caller-built payload.
module add8_stage import alu_pkg::*; #(
    parameter int unsigned DATA_W     = 8,
    parameter bit          RESET_DATA = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        a,
    input  logic [7:0]        b,
    input  logic              cin,
    output logic [7:0]        s,
    output logic              cout,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] d,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] q
);

    logic c4;
    logic vld_q;

    cla_4 u_grp_lo (
        .a    (a[GROUP_W-1:0]),
        .b    (b[GROUP_W-1:0]),
        .cin  (cin),
        .s    (s[GROUP_W-1:0]),
        .cout (c4)
    );

    cla_4 u_grp_hi (
        .a    (a[2*GROUP_W-1:GROUP_W]),
        .b    (b[2*GROUP_W-1:GROUP_W]),
        .cin  (c4),
        .s    (s[2*GROUP_W-1:GROUP_W]),
        .cout (cout)
    );

    // A leaving item may be replaced in the same cycle.
    assign in_ready  = ~vld_q | out_ready;
    assign out_valid = vld_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_q <= 1'b0;
        end else if (in_ready) begin
            vld_q <= in_valid;
        end
    end

    if (RESET_DATA) begin : g_rst_data
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                q <= '0;
            end else if (in_ready && in_valid) begin
                q <= d;
            end
        end
    end else begin : g_hold_data
        always_ff @(posedge clk) begin
            if (in_ready && in_valid) begin
                q <= d;
            end
        end
    end

endmodule

// File: rtl/cla_4.sv
// 4-bit carry-lookahead adder group.
module cla_4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] s,
    output logic       cout
);

    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;

    always_comb begin
        g    = a & b;
        p    = a ^ b;
        c[0] = cin;
        c[1] = g[0] | (p[0] & cin);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & cin);
        s    = p ^ c[3:0];
        cout = c[4];
    end

endmodule

// File: rtl/add16_pipe.sv
// Two-stage pipelined 16-bit add/subtract with carry, overflow and zero flags.
// Define ADD16_PIPE_SAT_EN to clamp overflowing results to the signed limits.
module add16_pipe import alu_pkg::*; #(
    parameter int unsigned WIDTH  = alu_pkg::WIDTH,
    parameter int unsigned GROUPS = alu_pkg::GROUPS
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             op_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovfl,
    output logic             zero
);

    if (WIDTH != 16 || WIDTH != GROUP_W * GROUPS) begin : g_bad_cfg
        $error("add16_pipe: WIDTH must be 16 and equal 4*GROUPS");
    end

    word_t      bx;
    logic [7:0] lo_s;
    logic       c8;
    s1_t        d1;
    s1_t        q1;
    logic       v1;
    logic       r2;
    logic [7:0] hi_s;
    logic       c16;
    word_t      raw;
    logic       ovf;
    word_t      res;
    res_t       d2;
    res_t       q2;

    // Subtract as A + ~B + 1; the +1 enters as the low group's carry-in.
    assign bx = b ^ {WIDTH{op_sub}};
    assign d1 = '{a_hi: a[15:8], b_hi: bx[15:8], c8: c8, lo: lo_s};

    add8_stage #(
        .DATA_W     ($bits(s1_t)),
        .RESET_DATA (1'b0)
    ) u_stage1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .a         (a[7:0]),
        .b         (bx[7:0]),
        .cin       (op_sub),
        .s         (lo_s),
        .cout      (c8),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .d         (d1),
        .out_valid (v1),
        .out_ready (r2),
        .q         (q1)
    );

    always_comb begin
        raw = {hi_s, q1.lo};
        ovf = (q1.a_hi[7] == q1.b_hi[7]) & (hi_s[7] != q1.a_hi[7]);
`ifdef ADD16_PIPE_SAT_EN
        res = ovf ? (q1.a_hi[7] ? 16'h8000 : 16'h7FFF) : raw;
`else
        res = raw;
`endif
        d2.sum        = res;
        d2.flags.cout = c16;
        d2.flags.ovfl = ovf;
        d2.flags.zero = (res == '0);
    end

    add8_stage #(
        .DATA_W     ($bits(res_t)),
        .RESET_DATA (1'b1)
    ) u_stage2 (
        .clk       (clk),
        .rst_n     (rst_n),
        .a         (q1.a_hi),
        .b         (q1.b_hi),
        .cin       (q1.c8),
        .s         (hi_s),
        .cout      (c16),
        .in_valid  (v1),
        .in_ready  (r2),
        .d         (d2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .q         (q2)
    );

    assign sum  = q2.sum;
    assign cout = q2.flags.cout;
    assign ovfl = q2.flags.ovfl;
    assign zero = q2.flags.zero;

endmodule

// File: tb/tb_add16_pipe.sv
// Scoreboard bench for add16_pipe: arithmetic reference model, decoupled monitor.
module tb_add16_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        op_sub;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] sum;
    logic        cout;
    logic        ovfl;
    logic        zero;

    always #5 clk = ~clk;

    add16_pipe dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op_sub    (op_sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovfl      (ovfl),
        .zero      (zero)
    );

    typedef struct {
        logic [15:0] sum;
        logic        cout;
        logic        ovfl;
        logic        zero;
        int          cyc;
    } exp_t;

    exp_t        sb_q[$];
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    bit          lat_chk = 1'b0;
    bit          stall_prev = 1'b0;
    bit          done;
    logic [18:0] held;

    // Reference: signed/unsigned integer arithmetic on the operand values.
    function automatic exp_t model(input logic [15:0] x, input logic [15:0] y, input logic s);
        exp_t        e;
        int          sx;
        int          sy;
        int          r;
        int unsigned ux;
        int unsigned uy;
        ux = {16'h0, x};
        uy = {16'h0, y};
        sx = x[15] ? int'(ux) - 65536 : int'(ux);
        sy = y[15] ? int'(uy) - 65536 : int'(uy);
        r = s ? sx - sy : sx + sy;
        e.cout = s ? (ux >= uy) : (ux + uy > 32'd65535);
        e.ovfl = (r > 32767) || (r < -32768);
        e.sum  = r[15:0];
`ifdef ADD16_PIPE_SAT_EN
        if (e.ovfl) e.sum = (r > 0) ? 16'h7FFF : 16'h8000;
`endif
        e.zero = (e.sum == 16'h0);
        e.cyc  = 0;
        return e;
    endfunction

    function automatic logic [15:0] rnd16();
        case ($urandom_range(0, 7))
            0: return 16'h7FFF;
            1: return 16'h8000;
            2: return 16'hFFFF;
            3: return 16'h0000;
            default: return 16'($urandom());
        endcase
    endfunction

    // Monitor: at each negedge, handshakes seen now complete at the next rising edge.
    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (!rst_n) begin
            sb_q.delete();
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                total++;
                if (!out_valid || {sum, cout, ovfl, zero} !== held) begin
                    bad++;
                    $display("FAIL stall_hold: got v=%b %h, want v=1 %h",
                             out_valid, {sum, cout, ovfl, zero}, held);
                end
            end
            if (out_valid && out_ready) begin
                total++;
                if (sb_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_output: got sum=%h with empty scoreboard, want none",
                             sum);
                end else begin
                    e = sb_q.pop_front();
                    if ({sum, cout, ovfl, zero} !== {e.sum, e.cout, e.ovfl, e.zero}) begin
                        bad++;
                        $display("FAIL result: got sum=%h c=%b v=%b z=%b, want sum=%h c=%b v=%b z=%b",
                                 sum, cout, ovfl, zero, e.sum, e.cout, e.ovfl, e.zero);
                    end
                    if (lat_chk) begin
                        total++;
                        if (cyc - e.cyc != 2) begin
                            bad++;
                            $display("FAIL latency: got %0d cycles, want 2", cyc - e.cyc);
                        end
                    end
                end
            end
            if (in_valid && in_ready) begin
                e = model(a, b, op_sub);
                e.cyc = cyc;
                sb_q.push_back(e);
            end
            stall_prev = out_valid && !out_ready;
            held = {sum, cout, ovfl, zero};
        end
    end

    task automatic send(input logic [15:0] x, input logic [15:0] y, input logic s,
                        input bit must_ready);
        int n;
        bit acc;
        n = 0;
        acc = 1'b0;
        a = x;
        b = y;
        op_sub = s;
        in_valid = 1'b1;
        while (!acc && n < 50) begin
            @(negedge clk);
            if (must_ready && n == 0) begin
                total++;
                if (in_ready !== 1'b1) begin
                    bad++;
                    $display("FAIL throughput_ready: got in_ready=%b, want 1", in_ready);
                end
            end
            if (in_ready === 1'b1) begin
                acc = 1'b1;
            end else begin
                n++;
                @(posedge clk);
                #1;
            end
        end
        total++;
        if (!acc) begin
            bad++;
            $display("FAIL send_timeout: got no accept in %0d cycles, want accept", n);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_reset(input string tag);
        @(negedge clk);
        total++;
        if ({out_valid, sum, cout, ovfl, zero} !== 20'h0) begin
            bad++;
            $display("FAIL %s_outputs: got v=%b sum=%h c=%b o=%b z=%b, want all 0",
                     tag, out_valid, sum, cout, ovfl, zero);
        end
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL %s_in_ready: got %b, want 1", tag, in_ready);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0;
        a = 16'h0;
        b = 16'h0;
        op_sub = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check_reset("reset");
        idle(1);

        // Directed arithmetic corners, one at a time with latency checks.
        lat_chk = 1'b1;
        send(16'h00FF, 16'h0001, 1'b0, 1'b1); idle(3);
        send(16'h1234, 16'h1234, 1'b1, 1'b1); idle(3);
        send(16'h7FFF, 16'h0001, 1'b0, 1'b1); idle(3);
        send(16'h8000, 16'h0001, 1'b1, 1'b1); idle(3);
        send(16'h0000, 16'h0001, 1'b1, 1'b1); idle(3);
        send(16'hFFFF, 16'h0001, 1'b0, 1'b1); idle(3);

        // Back-pressure: out_ready low for three cycles while four ops stream in.
        lat_chk = 1'b0;
        out_ready = 1'b0;
        fork
            begin
                send(16'h1111, 16'h2222, 1'b0, 1'b0);
                send(16'h8000, 16'h8000, 1'b0, 1'b0);
                @(negedge clk);
                total++;
                if (in_ready !== 1'b0) begin
                    bad++;
                    $display("FAIL full_in_ready: got %b, want 0", in_ready);
                end
                @(posedge clk);
                #1;
                send(16'h0005, 16'h0007, 1'b1, 1'b0);
                send(16'h4000, 16'hC000, 1'b1, 1'b0);
            end
            begin
                repeat (3) @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        idle(6);

        // Full throughput.
        lat_chk = 1'b1;
        for (int i = 0; i < 16; i++) begin
            send(rnd16(), rnd16(), 1'($urandom_range(0, 1)), 1'b1);
        end
        idle(4);

        // Random back-pressure.
        lat_chk = 1'b0;
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    send(rnd16(), rnd16(), 1'($urandom_range(0, 1)), 1'b0);
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    out_ready = 1'($urandom_range(0, 1));
                    @(posedge clk);
                    #1;
                end
                out_ready = 1'b1;
            end
        join
        idle(6);

        // Reset with two items in flight; nothing stale may emerge afterwards.
        lat_chk = 1'b1;
        send(16'h0101, 16'h0202, 1'b0, 1'b1);
        send(16'h0303, 16'h0404, 1'b0, 1'b1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check_reset("midreset");
        idle(8);
        send(16'hABCD, 16'h1234, 1'b1, 1'b1);
        idle(4);

        total++;
        if (sb_q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d results outstanding, want 0", sb_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
